// File: rtl/hdmi_rx_pkg.sv
// Shared HDMI receive constants, packet field types and the infoframe checksum helper.
// Pure definitions: no latency, no flow control.
package hdmi_rx_pkg;

    localparam logic [7:0] ECC_POLY     = 8'h83;
    localparam logic [7:0] VSIF_TYPE    = 8'h81;
    localparam logic [4:0] VSIF_MIN_LEN = 5'd5;

    localparam int HDR_DATA_W = 24;
    localparam int SUB_DATA_W = 56;
    localparam int NUM_SUB    = 4;

    typedef struct packed {
        logic [7:0] hb2;
        logic [7:0] hb1;
        logic [7:0] hb0;
    } hdr_t;

    typedef logic [NUM_SUB-1:0][SUB_DATA_W-1:0] sub_data_t;

    // PB(7i+j) is byte j of subpacket i, so summing every subpacket byte covers PB0..PB27.
    function automatic logic [7:0] packet_sum(input hdr_t hdr, input sub_data_t sub);
        logic [7:0] sum;
        sum = hdr.hb0 + hdr.hb1 + hdr.hb2;
        for (int i = 0; i < NUM_SUB; i++) begin
            for (int j = 0; j < SUB_DATA_W / 8; j++) begin
                sum = sum + sub[i][8*j +: 8];
            end
        end
        return sum;
    endfunction

endpackage

// File: rtl/vendor_infoframe_receiver_if.sv
// Data-island bit stream in, decoded packet and VSIF fields out.
// No backpressure: the source streams bits every pixel clock while data_island_period is high.
interface vendor_infoframe_receiver_if;
    import hdmi_rx_pkg::*;

    logic                 data_island_period;
    logic [8:0]           packet_data;
    logic                 packet_valid;
    logic [23:0]          header;
    sub_data_t            sub;
    logic [4:0]           ecc_error;
    logic                 checksum_ok;
    logic                 vsif_valid;
    logic [23:0]          ieee_oui;
    logic [2:0]           hdmi_video_format;
    logic [7:0]           hdmi_vic;

    modport master (
        output data_island_period, packet_data,
        input  packet_valid, header, sub, ecc_error, checksum_ok,
               vsif_valid, ieee_oui, hdmi_video_format, hdmi_vic
    );

    modport slave (
        input  data_island_period, packet_data,
        output packet_valid, header, sub, ecc_error, checksum_ok,
               vsif_valid, ieee_oui, hdmi_video_format, hdmi_vic
    );

endinterface

// File: rtl/packet_ecc_check.sv
// BCH parity check of one packet channel: LFSR over DATA_W data bits vs the 8 parity bits above them.
// Combinational, no flow control.
module packet_ecc_check
    import hdmi_rx_pkg::*;
#(
    parameter int DATA_W = 24
) (
    input  logic [DATA_W+7:0] word,
    output logic              error
);

    logic [7:0] ecc;
    logic       fb;

    // Serial LFSR unrolled across the data bits, LSB first as transmitted.
    always_comb begin
        ecc = 8'h00;
        fb  = 1'b0;
        for (int b = 0; b < DATA_W; b++) begin
            fb  = word[b] ^ ecc[0];
            ecc = (ecc >> 1) ^ (fb ? ECC_POLY : 8'h00);
        end
        error = (ecc != word[DATA_W+7:DATA_W]);
    end

endmodule

// File: rtl/vendor_infoframe_receiver.sv
// Assembles 32-cycle HDMI data-island packets, checks ECC/checksum, decodes the vendor-specific infoframe.
// Packet outputs register 1 cycle after the count-31 sample; no backpressure, back-to-back packets accepted.
module vendor_infoframe_receiver
    import hdmi_rx_pkg::*;
#(
    parameter bit REQUIRE_VALID = 1'b1
) (
    input  logic                          clk_pixel,
    input  logic                          reset,
    vendor_infoframe_receiver_if.slave    rx
);

    logic [4:0]                bit_cnt;
    logic [31:0]               hdr_sr;
    logic [NUM_SUB-1:0][63:0]  sub_sr;

    logic [31:0]               hdr_word;
    logic [NUM_SUB-1:0][63:0]  sub_word;
    hdr_t                      hdr_data;
    sub_data_t                 sub_data;
    logic [4:0]                ecc_now;
    logic                      csum_now;
    logic                      last_bit;
    logic                      is_vsif;
    logic                      accept_vsif;

    logic                      packet_valid_q;
    logic [23:0]               header_q;
    sub_data_t                 sub_q;
    logic [4:0]                ecc_error_q;
    logic                      checksum_ok_q;
    logic                      vsif_valid_q;
    logic [23:0]               ieee_oui_q;
    logic [2:0]                hdmi_video_format_q;
    logic [7:0]                hdmi_vic_q;

    assign last_bit = rx.data_island_period && (bit_cnt == 5'd31);

    // Right shifts with the new sample entering at the top leave the bit taken at count k in position k
    // after 32 samples; the word is viewed here including the current sample so count 31 completes it.
    always_comb begin
        hdr_word = {rx.packet_data[0], hdr_sr[31:1]};
        for (int i = 0; i < NUM_SUB; i++) begin
            sub_word[i] = {rx.packet_data[5+i], rx.packet_data[1+i], sub_sr[i][63:2]};
        end
    end

    always_comb begin
        hdr_data = hdr_word[23:0];
        for (int i = 0; i < NUM_SUB; i++) begin
            sub_data[i] = sub_word[i][55:0];
        end
    end

    packet_ecc_check #(.DATA_W(HDR_DATA_W)) u_hdr_ecc (
        .word  (hdr_word),
        .error (ecc_now[4])
    );

    for (genvar g = 0; g < NUM_SUB; g++) begin : g_sub_ecc
        packet_ecc_check #(.DATA_W(SUB_DATA_W)) u_sub_ecc (
            .word  (sub_word[g]),
            .error (ecc_now[g])
        );
    end

    assign csum_now    = (packet_sum(hdr_data, sub_data) == 8'h00);
    assign is_vsif     = (hdr_data.hb0 == VSIF_TYPE) && (hdr_data.hb2[4:0] >= VSIF_MIN_LEN);
    assign accept_vsif = is_vsif && (!REQUIRE_VALID || ((ecc_now == 5'd0) && csum_now));

    // A falling data_island_period clears the count, which also discards any partial packet.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            bit_cnt <= 5'd0;
            hdr_sr  <= '0;
            sub_sr  <= '0;
        end else if (rx.data_island_period) begin
            bit_cnt <= bit_cnt + 5'd1;
            hdr_sr  <= hdr_word;
            sub_sr  <= sub_word;
        end else begin
            bit_cnt <= 5'd0;
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            packet_valid_q <= 1'b0;
            header_q       <= '0;
            sub_q          <= '0;
            ecc_error_q    <= '0;
            checksum_ok_q  <= 1'b0;
        end else begin
            packet_valid_q <= last_bit;
            if (last_bit) begin
                header_q      <= hdr_data;
                sub_q         <= sub_data;
                ecc_error_q   <= ecc_now;
                checksum_ok_q <= csum_now;
            end
        end
    end

    // PB1..PB5 live in subpacket 0 bytes 1..5.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            vsif_valid_q        <= 1'b0;
            ieee_oui_q          <= '0;
            hdmi_video_format_q <= '0;
            hdmi_vic_q          <= '0;
        end else if (last_bit && accept_vsif) begin
            vsif_valid_q        <= 1'b1;
            ieee_oui_q          <= sub_data[0][31:8];
            hdmi_video_format_q <= sub_data[0][39:37];
            hdmi_vic_q          <= sub_data[0][47:40];
        end
    end

    assign rx.packet_valid      = packet_valid_q;
    assign rx.header            = header_q;
    assign rx.sub               = sub_q;
    assign rx.ecc_error         = ecc_error_q;
    assign rx.checksum_ok       = checksum_ok_q;
    assign rx.vsif_valid        = vsif_valid_q;
    assign rx.ieee_oui          = ieee_oui_q;
    assign rx.hdmi_video_format = hdmi_video_format_q;
    assign rx.hdmi_vic          = hdmi_vic_q;

endmodule

// File: tb/tb_vendor_infoframe_receiver.sv
// Directed bench for vendor_infoframe_receiver: serialises packets with bench-computed parity.
module tb_vendor_infoframe_receiver;

    logic clk_pixel = 1'b0;
    logic reset     = 1'b1;

    always #5 clk_pixel = ~clk_pixel;

    vendor_infoframe_receiver_if ifc ();

    vendor_infoframe_receiver #(.REQUIRE_VALID(1'b1)) dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .rx        (ifc)
    );

    localparam logic [23:0] VSIF_HDR  = 24'h050181;
    localparam logic [23:0] SHORT_HDR = 24'h040181;
    localparam logic [23:0] AVI_HDR   = 24'h0D0282;

    int vectors     = 0;
    int miscompares = 0;

    logic [3:0][55:0] vsif_sub;
    logic [3:0][55:0] bad_sub;
    logic [3:0][55:0] short_sub;
    logic [3:0][55:0] zero_sub;

    int          cyc = 0;
    int          pv_cnt = 0;
    int          pv_last_cyc = 0;
    int          pv_prev_cyc = 0;
    logic        pv_last_vsif = 1'b0;
    logic        pv_prev_vsif = 1'b0;
    logic [23:0] pv_last_hdr = '0;
    logic [23:0] pv_prev_hdr = '0;

    always @(posedge clk_pixel) cyc = cyc + 1;

    always @(negedge clk_pixel) begin
        if (ifc.packet_valid === 1'b1) begin
            pv_prev_cyc  = pv_last_cyc;
            pv_prev_vsif = pv_last_vsif;
            pv_prev_hdr  = pv_last_hdr;
            pv_last_cyc  = cyc;
            pv_last_vsif = ifc.vsif_valid;
            pv_last_hdr  = ifc.header;
            pv_cnt       = pv_cnt + 1;
        end
    end

    function automatic logic [7:0] ecc_of(input logic [55:0] d, input int n);
        logic [7:0] e;
        logic       f;
        e = 8'h00;
        for (int b = 0; b < n; b++) begin
            f = d[b] ^ e[0];
            e = (e >> 1) ^ (f ? 8'h83 : 8'h00);
        end
        return e;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_pixel);
            ifc.data_island_period = 1'b0;
            ifc.packet_data        = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_pixel);
        reset                  = 1'b1;
        ifc.data_island_period = 1'b0;
        ifc.packet_data        = '0;
        repeat (2) @(negedge clk_pixel);
        reset = 1'b0;
    endtask

    // Drives the first ncyc bit slots of a packet; parity is computed here, then optionally corrupted.
    task automatic send(input logic [23:0] hdr, input logic [3:0][55:0] sd, input int ncyc,
                        input logic [31:0] hflip, input logic [3:0][63:0] sflip);
        logic [31:0]      hw;
        logic [3:0][63:0] sw;
        logic [8:0]       pd;
        hw = {ecc_of({32'h0, hdr}, 24), hdr} ^ hflip;
        for (int i = 0; i < 4; i++) sw[i] = {ecc_of(sd[i], 56), sd[i]} ^ sflip[i];
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk_pixel);
            pd[0] = hw[k];
            for (int i = 0; i < 4; i++) begin
                pd[1+i] = sw[i][2*k];
                pd[5+i] = sw[i][2*k+1];
            end
            ifc.data_island_period = 1'b1;
            ifc.packet_data        = pd;
        end
    endtask

    task automatic test_reset();
        ifc.data_island_period = 1'b0;
        ifc.packet_data        = '0;
        repeat (3) @(negedge clk_pixel);
        #1;
        vectors++; if (ifc.packet_valid !== 1'b0) begin miscompares++; $display("FAIL reset_pv got %b want 0", ifc.packet_valid); end
        vectors++; if (ifc.header !== 24'h0) begin miscompares++; $display("FAIL reset_header got %h want 000000", ifc.header); end
        vectors++; if (ifc.ecc_error !== 5'h0 || ifc.checksum_ok !== 1'b0) begin miscompares++; $display("FAIL reset_status got ecc=%b csum=%b want 00000/0", ifc.ecc_error, ifc.checksum_ok); end
        vectors++; if (ifc.vsif_valid !== 1'b0 || ifc.ieee_oui !== 24'h0 || ifc.hdmi_vic !== 8'h0 || ifc.hdmi_video_format !== 3'h0) begin miscompares++; $display("FAIL reset_decode got v=%b oui=%h vic=%h fmt=%h want all 0", ifc.vsif_valid, ifc.ieee_oui, ifc.hdmi_vic, ifc.hdmi_video_format); end
        @(negedge clk_pixel);
        reset = 1'b0;
    endtask

    task automatic test_good_vsif();
        int n0;
        do_reset();
        n0 = pv_cnt;
        send(VSIF_HDR, vsif_sub, 32, '0, '0);
        #1;
        vectors++; if (ifc.packet_valid !== 1'b0) begin miscompares++; $display("FAIL good_pv_early got %b want 0", ifc.packet_valid); end
        idle(1);
        #1;
        vectors++; if (ifc.packet_valid !== 1'b1) begin miscompares++; $display("FAIL good_pv got %b want 1", ifc.packet_valid); end
        vectors++; if (ifc.header !== VSIF_HDR) begin miscompares++; $display("FAIL good_header got %h want %h", ifc.header, VSIF_HDR); end
        vectors++; if (ifc.sub[0] !== vsif_sub[0]) begin miscompares++; $display("FAIL good_sub0 got %h want %h", ifc.sub[0], vsif_sub[0]); end
        vectors++; if (ifc.ecc_error !== 5'b00000) begin miscompares++; $display("FAIL good_ecc got %b want 00000", ifc.ecc_error); end
        vectors++; if (ifc.checksum_ok !== 1'b1) begin miscompares++; $display("FAIL good_csum got %b want 1", ifc.checksum_ok); end
        vectors++; if (ifc.ieee_oui !== 24'h000C03) begin miscompares++; $display("FAIL good_oui got %h want 000c03", ifc.ieee_oui); end
        vectors++; if (ifc.hdmi_video_format !== 3'b001) begin miscompares++; $display("FAIL good_fmt got %b want 001", ifc.hdmi_video_format); end
        vectors++; if (ifc.hdmi_vic !== 8'h01) begin miscompares++; $display("FAIL good_vic got %h want 01", ifc.hdmi_vic); end
        vectors++; if (ifc.vsif_valid !== 1'b1) begin miscompares++; $display("FAIL good_vsif_valid got %b want 1", ifc.vsif_valid); end
        idle(1);
        #1;
        vectors++; if (ifc.packet_valid !== 1'b0) begin miscompares++; $display("FAIL good_pv_one_cycle got %b want 0", ifc.packet_valid); end
        vectors++; if (pv_cnt !== n0 + 1) begin miscompares++; $display("FAIL good_pv_count got %0d want %0d", pv_cnt, n0 + 1); end
        vectors++; if (ifc.vsif_valid !== 1'b1 || ifc.header !== VSIF_HDR) begin miscompares++; $display("FAIL good_hold got v=%b hdr=%h want 1/%h", ifc.vsif_valid, ifc.header, VSIF_HDR); end
    endtask

    task automatic test_checksum_error();
        do_reset();
        send(VSIF_HDR, bad_sub, 32, '0, '0);
        idle(1);
        #1;
        vectors++; if (ifc.packet_valid !== 1'b1) begin miscompares++; $display("FAIL csum_pv got %b want 1", ifc.packet_valid); end
        vectors++; if (ifc.checksum_ok !== 1'b0) begin miscompares++; $display("FAIL csum_ok got %b want 0", ifc.checksum_ok); end
        vectors++; if (ifc.ecc_error !== 5'b00000) begin miscompares++; $display("FAIL csum_ecc got %b want 00000", ifc.ecc_error); end
        vectors++; if (ifc.vsif_valid !== 1'b0 || ifc.ieee_oui !== 24'h0 || ifc.hdmi_vic !== 8'h0) begin miscompares++; $display("FAIL csum_no_decode got v=%b oui=%h vic=%h want 0/000000/00", ifc.vsif_valid, ifc.ieee_oui, ifc.hdmi_vic); end
    endtask

    task automatic test_ecc_errors();
        logic [3:0][63:0] sflip;
        do_reset();
        send(VSIF_HDR, vsif_sub, 32, 32'h0100_0000, '0);
        idle(1);
        #1;
        vectors++; if (ifc.ecc_error !== 5'b10000) begin miscompares++; $display("FAIL hdr_ecc got %b want 10000", ifc.ecc_error); end
        vectors++; if (ifc.checksum_ok !== 1'b1) begin miscompares++; $display("FAIL hdr_ecc_csum got %b want 1", ifc.checksum_ok); end
        vectors++; if (ifc.vsif_valid !== 1'b0 || ifc.ieee_oui !== 24'h0) begin miscompares++; $display("FAIL hdr_ecc_no_decode got v=%b oui=%h want 0/000000", ifc.vsif_valid, ifc.ieee_oui); end
        sflip    = '0;
        sflip[2] = 64'h1000_0000_0000_0000;
        send(VSIF_HDR, vsif_sub, 32, '0, sflip);
        idle(1);
        #1;
        vectors++; if (ifc.ecc_error !== 5'b00100) begin miscompares++; $display("FAIL sub2_ecc got %b want 00100", ifc.ecc_error); end
        vectors++; if (ifc.vsif_valid !== 1'b0) begin miscompares++; $display("FAIL sub2_ecc_no_decode got %b want 0", ifc.vsif_valid); end
    endtask

    task automatic test_short_length();
        do_reset();
        send(SHORT_HDR, short_sub, 32, '0, '0);
        idle(1);
        #1;
        vectors++; if (ifc.header !== SHORT_HDR || ifc.checksum_ok !== 1'b1 || ifc.ecc_error !== 5'b0) begin miscompares++; $display("FAIL short_pkt got hdr=%h csum=%b ecc=%b want %h/1/00000", ifc.header, ifc.checksum_ok, ifc.ecc_error, SHORT_HDR); end
        vectors++; if (ifc.vsif_valid !== 1'b0 || ifc.ieee_oui !== 24'h0) begin miscompares++; $display("FAIL short_no_decode got v=%b oui=%h want 0/000000", ifc.vsif_valid, ifc.ieee_oui); end
    endtask

    task automatic test_abort();
        int n0;
        do_reset();
        n0 = pv_cnt;
        send(VSIF_HDR, vsif_sub, 17, '0, '0);
        idle(3);
        #1;
        vectors++; if (pv_cnt !== n0) begin miscompares++; $display("FAIL abort_no_pv got %0d strobes want 0", pv_cnt - n0); end
        send(VSIF_HDR, vsif_sub, 32, '0, '0);
        idle(1);
        #1;
        vectors++; if (ifc.packet_valid !== 1'b1 || pv_cnt !== n0 + 1) begin miscompares++; $display("FAIL abort_next_pv got pv=%b n=%0d want 1/1", ifc.packet_valid, pv_cnt - n0); end
        vectors++; if (ifc.vsif_valid !== 1'b1 || ifc.ieee_oui !== 24'h000C03 || ifc.hdmi_vic !== 8'h01) begin miscompares++; $display("FAIL abort_next_decode got v=%b oui=%h vic=%h want 1/000c03/01", ifc.vsif_valid, ifc.ieee_oui, ifc.hdmi_vic); end
    endtask

    task automatic test_reset_mid_packet();
        send(VSIF_HDR, vsif_sub, 10, '0, '0);
        @(negedge clk_pixel);
        reset = 1'b1;
        #1;
        vectors++; if (ifc.vsif_valid !== 1'b0 || ifc.ieee_oui !== 24'h0 || ifc.hdmi_vic !== 8'h0 || ifc.hdmi_video_format !== 3'h0) begin miscompares++; $display("FAIL midrst_decode got v=%b oui=%h vic=%h fmt=%h want all 0", ifc.vsif_valid, ifc.ieee_oui, ifc.hdmi_vic, ifc.hdmi_video_format); end
        vectors++; if (ifc.header !== 24'h0 || ifc.sub !== '0 || ifc.ecc_error !== 5'h0 || ifc.checksum_ok !== 1'b0 || ifc.packet_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_pkt got hdr=%h ecc=%b csum=%b pv=%b want all 0", ifc.header, ifc.ecc_error, ifc.checksum_ok, ifc.packet_valid); end
        ifc.data_island_period = 1'b0;
        ifc.packet_data        = '0;
        @(negedge clk_pixel);
        reset = 1'b0;
        send(VSIF_HDR, vsif_sub, 32, '0, '0);
        idle(1);
        #1;
        vectors++; if (ifc.packet_valid !== 1'b1 || ifc.header !== VSIF_HDR) begin miscompares++; $display("FAIL midrst_next_pkt got pv=%b hdr=%h want 1/%h", ifc.packet_valid, ifc.header, VSIF_HDR); end
        vectors++; if (ifc.vsif_valid !== 1'b1 || ifc.ieee_oui !== 24'h000C03 || ifc.hdmi_video_format !== 3'b001) begin miscompares++; $display("FAIL midrst_next_decode got v=%b oui=%h fmt=%b want 1/000c03/001", ifc.vsif_valid, ifc.ieee_oui, ifc.hdmi_video_format); end
    endtask

    task automatic test_back_to_back();
        int n0;
        do_reset();
        n0 = pv_cnt;
        send(AVI_HDR, zero_sub, 32, '0, '0);
        send(VSIF_HDR, vsif_sub, 32, '0, '0);
        idle(1);
        #1;
        vectors++; if (pv_cnt !== n0 + 2) begin miscompares++; $display("FAIL b2b_count got %0d strobes want 2", pv_cnt - n0); end
        vectors++; if (pv_last_cyc - pv_prev_cyc !== 32) begin miscompares++; $display("FAIL b2b_spacing got %0d cycles want 32", pv_last_cyc - pv_prev_cyc); end
        vectors++; if (pv_prev_hdr !== AVI_HDR || pv_prev_vsif !== 1'b0) begin miscompares++; $display("FAIL b2b_first got hdr=%h v=%b want %h/0", pv_prev_hdr, pv_prev_vsif, AVI_HDR); end
        vectors++; if (ifc.header !== VSIF_HDR || ifc.vsif_valid !== 1'b1 || ifc.ieee_oui !== 24'h000C03 || ifc.hdmi_vic !== 8'h01) begin miscompares++; $display("FAIL b2b_second got hdr=%h v=%b oui=%h vic=%h want %h/1/000c03/01", ifc.header, ifc.vsif_valid, ifc.ieee_oui, ifc.hdmi_vic, VSIF_HDR); end
    endtask

    initial begin
        zero_sub     = '0;
        vsif_sub     = '0;
        vsif_sub[0]  = 56'h00_01_20_00_0C_03_49;
        bad_sub      = '0;
        bad_sub[0]   = 56'h00_01_20_00_0C_03_48;
        short_sub    = '0;
        short_sub[0] = 56'h00_01_20_00_0C_03_4A;
        ifc.data_island_period = 1'b0;
        ifc.packet_data        = '0;

        test_reset();
        test_good_vsif();
        test_checksum_error();
        test_ecc_errors();
        test_short_length();
        test_abort();
        test_reset_mid_packet();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vendor_infoframe_receiver.md
VENDOR_INFOFRAME_RECEIVER -- requirements
Module: vendor_infoframe_receiver

Interface
REQ-001 SHALL have parameter REQUIRE_VALID, default 1: when 1, decoded VSIF fields update only from packets with no ECC error and a correct checksum.
REQ-002 SHALL have port clk_pixel, input, 1, pixel clock; sole clock.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port data_island_period, input, 1, high while packet bits are present.
REQ-005 SHALL have port packet_data, input, 9: bit0 is a header bit; bit(1+i) is the even bit and bit(5+i) is the odd bit of subpacket i.
REQ-006 SHALL have port packet_valid, output, 1, one-cycle strobe marking a completed packet.
REQ-007 SHALL have port header, output, 24, last packet header, HB0 in [7:0].
REQ-008 SHALL have port sub, output, 4x56, last packet subpackets, byte 0 in [7:0].
REQ-009 SHALL have port ecc_error, output, 5: bit4 is the header channel, bits3:0 are subpackets 3:0.
REQ-010 SHALL have port checksum_ok, output, 1, infoframe checksum result.
REQ-011 SHALL have port vsif_valid, output, 1, sticky; set when a good VSIF has been decoded.
REQ-012 SHALL have port ieee_oui, output, 24, {PB3,PB2,PB1}.
REQ-013 SHALL have port hdmi_video_format, output, 3, PB4[7:5].
REQ-014 SHALL have port hdmi_vic, output, 8, PB5.

Function
REQ-015 SHALL keep a 5-bit bit counter that increments on each cycle data_island_period is high and wraps 31->0.
- Back-to-back packets are accepted with no gap.
REQ-016 SHALL, per cycle at count k:
- shift packet_data[0] into header-channel bit k;
- shift packet_data[1+i] into subpacket i bit 2k, and packet_data[5+i] into bit 2k+1.
REQ-017 SHALL, when data_island_period falls before count 31, discard the partial packet and clear the counter, with no packet_valid.
REQ-018 SHALL check ECC on each channel:
- Header channel: bits 0..23 are data, bits 24..31 are parity.
- Subpacket channels: bits 0..55 are data, bits 56..63 are parity.
- LFSR starts at 0; per data bit, f = bit XOR ecc[0] and ecc = (ecc >> 1) XOR (f ? 8'h83 : 0).
- The mismatch of final ecc against received parity sets the channel's ecc_error bit.
REQ-019 SHALL form packet bytes with PB(7i+j) = sub[i] byte j, for j=0..6.
REQ-020 SHALL set checksum_ok when (HB0+HB1+HB2+PB0+...+PB27) mod 256 == 0.
REQ-021 SHALL, in the cycle after the count-31 sample, register header, sub, ecc_error and checksum_ok and pulse packet_valid (latency 1).
- These outputs hold until the next completed packet.
REQ-022 SHALL treat a packet as a VSIF when HB0 == 8'h81 and HB2[4:0] >= 5.
REQ-023 SHALL, for a VSIF, update ieee_oui, hdmi_video_format and hdmi_vic and set vsif_valid in the same cycle as packet_valid.
- When REQUIRE_VALID=1, this happens only if ecc_error == 0 and checksum_ok == 1.
- Otherwise the previously decoded fields hold.
REQ-024 SHALL ignore a non-VSIF packet for decoding; decoded fields are unchanged, and the REQ-021 outputs update as normal.
REQ-025 SHALL let a new packet's first bit, sampled in the same cycle as packet_valid, proceed unaffected.

Reset
REQ-026 SHALL clear all state while reset is high, independent of clk_pixel.
- Counter, shift registers, header, sub, ieee_oui, hdmi_vic clear to 0.
- ecc_error, checksum_ok, packet_valid, vsif_valid, hdmi_video_format clear to 0.
REQ-027 SHALL, on reset asserted mid-packet, drop the partial packet; reception restarts at count 0 on the first data_island_period cycle after release.

Structure
REQ-028 SHALL take the ECC polynomial constant 8'h83, the VSIF type 8'h81 and the minimum length 5 from shared package hdmi_rx_pkg.
REQ-029 SHALL instantiate five copies of sub-module packet_ecc_check, one per channel, parameterised by data width (24/56).
- packet_ecc_check performs the serial LFSR, parity compare and error flag.

Verification
REQ-030 SHALL verify a good VSIF:
- Stimulus: header 24'h050181; PB0..PB5 = 49,03,0C,00,20,01, rest 0; correct parity on all channels.
- Response: packet_valid one cycle after count 31, checksum_ok=1, ecc_error=0, ieee_oui=24'h000C03, hdmi_video_format=3'b001, hdmi_vic=8'h01, vsif_valid=1.
REQ-031 SHALL verify a checksum error: the same packet with PB0=8'h48 -> checksum_ok=0, decoded fields and vsif_valid unchanged.
REQ-032 SHALL verify a header ECC error: one header parity bit flipped -> ecc_error=5'b10000, no decode update.
REQ-033 SHALL verify an aborted packet: data_island_period drops at count 17 -> no packet_valid; the next full packet decodes correctly.
REQ-034 SHALL verify back-to-back reception: two packets on 64 contiguous cycles, an AVI header 24'h0D0282 then the VSIF -> two packet_valid strobes 32 cycles apart, only the second updates decoded fields.
REQ-035 SHALL verify reset mid-packet: reset asserted at count 10 -> all outputs 0 immediately; a following full VSIF decodes correctly.
